// File: rtl/vload_lane_aligner.sv
// Multi-lane vector load aligner: picks a byte/half/word per lane out of a memory
// line, extends it to WIDTH, and hands it to writeback through a two-stage pipeline.
module vload_lane_aligner #(
  parameter int WIDTH         = 32,
  parameter int LINEWIDTH     = 128,
  parameter int LOG2LINEBYTES = 4,
  parameter int NUMLANES      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LINEWIDTH-1:0]              in_data,
  input  logic [NUMLANES*LOG2LINEBYTES-1:0] in_offsets,
  input  logic [NUMLANES-1:0]               in_lanemask,
  input  logic [1:0]                        load_size,
  input  logic                              load_sign_ext,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUMLANES*WIDTH-1:0]         out_data,
  output logic [NUMLANES-1:0]               out_mask,
  output logic [NUMLANES-1:0]               out_misaligned
);

  localparam int LINEBYTES = LINEWIDTH / 8;

  logic                     s2_free;
  logic                     s1_adv;
  logic                     s1_valid;
  logic [31:0]              s1_raw [NUMLANES];
  logic [1:0]               s1_size;
  logic                     s1_sext;
  logic [NUMLANES-1:0]      s1_mask;
  logic [NUMLANES-1:0]      s1_mis;

  logic [7:0]               line_bytes [LINEBYTES];
  logic [LOG2LINEBYTES-1:0] off  [NUMLANES];
  logic [LOG2LINEBYTES-1:0] base [NUMLANES];
  logic [31:0]              sel_raw [NUMLANES];
  logic [NUMLANES-1:0]      sel_mis;
  logic [NUMLANES*WIDTH-1:0] ext_data;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;

  // Byte 0 sits at the top of the line (big-endian numbering).
  always_comb begin
    for (int k = 0; k < LINEBYTES; k++) begin
      line_bytes[k] = in_data[LINEWIDTH-1-8*k -: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      off[i]     = in_offsets[i*LOG2LINEBYTES +: LOG2LINEBYTES];
      base[i]    = off[i];
      sel_raw[i] = '0;
      sel_mis[i] = 1'b0;
      case (load_size)
        2'b00: begin
          sel_raw[i] = {24'd0, line_bytes[base[i]]};
        end
        2'b01: begin
          base[i]    = {off[i][LOG2LINEBYTES-1:1], 1'b0};
          sel_raw[i] = {16'd0, line_bytes[base[i]],
                        line_bytes[base[i] + LOG2LINEBYTES'(1)]};
          sel_mis[i] = off[i][0];
        end
        default: begin
          base[i]    = {off[i][LOG2LINEBYTES-1:2], 2'b00};
          sel_raw[i] = {line_bytes[base[i]],
                        line_bytes[base[i] + LOG2LINEBYTES'(1)],
                        line_bytes[base[i] + LOG2LINEBYTES'(2)],
                        line_bytes[base[i] + LOG2LINEBYTES'(3)]};
          sel_mis[i] = |off[i][1:0];
        end
      endcase
      if (!in_lanemask[i]) begin
        sel_raw[i] = '0;
        sel_mis[i] = 1'b0;
      end
    end
  end

  // Fill with the sign bit first, then overlay the element; works for WIDTH == 32 too.
  function automatic logic [WIDTH-1:0] extend(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sext);
    logic [WIDTH-1:0] r;
    case (size)
      2'b00: begin
        r       = {WIDTH{sext & raw[7]}};
        r[7:0]  = raw[7:0];
      end
      2'b01: begin
        r       = {WIDTH{sext & raw[15]}};
        r[15:0] = raw[15:0];
      end
      default: begin
        r       = {WIDTH{sext & raw[31]}};
        r[31:0] = raw;
      end
    endcase
    return r;
  endfunction

  always_comb begin
    ext_data = '0;
    for (int i = 0; i < NUMLANES; i++) begin
      ext_data[i*WIDTH +: WIDTH] = extend(s1_raw[i], s1_size, s1_sext);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_size        <= 2'b00;
      s1_sext        <= 1'b0;
      s1_mask        <= '0;
      s1_mis         <= '0;
      for (int i = 0; i < NUMLANES; i++) s1_raw[i] <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_mask       <= '0;
      out_misaligned <= '0;
    end else begin
      // S1 can only be overwritten when it is empty or draining into S2.
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_raw  <= sel_raw;
          s1_size <= load_size;
          s1_sext <= load_sign_ext;
          s1_mask <= in_lanemask;
          s1_mis  <= sel_mis;
        end
      end
      if (s2_free) begin
        out_valid <= s1_adv;
        if (s1_adv) begin
          out_data       <= ext_data;
          out_mask       <= s1_mask;
          out_misaligned <= s1_mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_vload_lane_aligner.sv
// Scoreboard bench for vload_lane_aligner: expectations are queued at acceptance
// and compared by a monitor whenever an output transfer completes.
module tb_vload_lane_aligner;

  localparam logic [127:0] LINE = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   mask;
    logic [3:0]   mis;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_offsets;
  logic [3:0]   in_lanemask;
  logic [1:0]   load_size;
  logic         load_sign_ext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_mask;
  logic [3:0]   out_misaligned;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  vload_lane_aligner #(
    .WIDTH(32), .LINEWIDTH(128), .LOG2LINEBYTES(4), .NUMLANES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offsets(in_offsets), .in_lanemask(in_lanemask),
    .load_size(load_size), .load_sign_ext(load_sign_ext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  // Reference model written from the byte-numbering rules, lane by lane.
  function automatic exp_t model(input logic [127:0] line, input logic [15:0] offs,
                                 input logic [3:0] mask, input logic [1:0] size,
                                 input logic sext);
    exp_t r;
    int nb, o, eo;
    logic [63:0]  v;
    logic [127:0] sh;
    r  = '0;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        o  = int'(offs[i*4 +: 4]);
        eo = o - (o % nb);
        v  = '0;
        for (int j = 0; j < nb; j++) begin
          sh = line >> (8 * (15 - (eo + j)));
          v  = (v << 8) | {56'd0, sh[7:0]};
        end
        if (sext && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        r.data[i*32 +: 32] = v[31:0];
        r.mis[i]  = (o % nb) != 0;
        r.mask[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_output got data=%h with empty scoreboard", out_data);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (out_data !== mon_e.data) begin
          errors++;
          $display("[TB] FAIL out_data got=%h want=%h", out_data, mon_e.data);
        end
        checks++;
        if (out_mask !== mon_e.mask) begin
          errors++;
          $display("[TB] FAIL out_mask got=%b want=%b", out_mask, mon_e.mask);
        end
        checks++;
        if (out_misaligned !== mon_e.mis) begin
          errors++;
          $display("[TB] FAIL out_misaligned got=%b want=%b", out_misaligned, mon_e.mis);
        end
      end
    end
  end

  task automatic send(input logic [15:0] offs, input logic [3:0] mask,
                      input logic [1:0] size, input logic sext, input exp_t e,
                      output int waited);
    in_valid      = 1'b1;
    in_data       = LINE;
    in_offsets    = offs;
    in_lanemask   = mask;
    load_size     = size;
    load_sign_ext = sext;
    waited        = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout in_ready got=%b want=1", in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_data       = {$urandom, $urandom, $urandom, $urandom};
    in_offsets    = 16'($urandom);
    in_lanemask   = 4'($urandom);
    load_size     = 2'($urandom);
    load_sign_ext = 1'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("[TB] FAIL %s_drain pending got=%0d want=0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_latency(input string name);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_latency1 out_valid got=%b want=0", name, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_latency2 out_valid got=%b want=1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_mask, out_misaligned} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%b d=%h m=%b x=%b want all 0",
               out_valid, out_data, out_mask, out_misaligned);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_zext();
    int w;
    send({4'd8, 4'd15, 4'd5, 4'd0}, 4'b1111, 2'b00, 1'b0,
         '{data: 128'h00000088_000000FF_00000055_00000000, mask: 4'b1111, mis: 4'b0000}, w);
    idle();
    check_latency("byte_zext");
    wait_drain("byte_zext");
  endtask

  task automatic test_byte_sext();
    int w;
    send({4'd10, 4'd1, 4'd15, 4'd8}, 4'b1111, 2'b00, 1'b1,
         '{data: 128'hFFFFFFAA_00000011_FFFFFFFF_FFFFFF88, mask: 4'b1111, mis: 4'b0000}, w);
    idle();
    wait_drain("byte_sext");
  endtask

  task automatic test_half_mask();
    int w;
    send({4'd14, 4'd0, 4'd5, 4'd10}, 4'b1011, 2'b01, 1'b1,
         '{data: 128'hFFFFEEFF_00000000_00004455_FFFFAABB, mask: 4'b1011, mis: 4'b0010}, w);
    idle();
    wait_drain("half_mask");
  endtask

  task automatic test_word();
    int w;
    send({4'd4, 4'd7, 4'd0, 4'd12}, 4'b1111, 2'b10, 1'b1,
         '{data: 128'h44556677_44556677_00112233_CCDDEEFF, mask: 4'b1111, mis: 4'b0100}, w);
    idle();
    wait_drain("word");
  endtask

  task automatic test_back_to_back();
    int w;
    logic [15:0] o;
    logic [3:0]  m;
    logic [1:0]  s;
    logic        x;
    for (int k = 0; k < 8; k++) begin
      o = 16'($urandom); m = 4'($urandom); s = 2'($urandom); x = 1'($urandom);
      send(o, m, s, x, model(LINE, o, m, s, x), w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("[TB] FAIL b2b_stall item=%0d wait got=%0d want=0", k, w);
      end
    end
    idle();
    wait_drain("b2b");
  endtask

  task automatic test_backpressure();
    fork
      begin
        int w;
        logic [15:0] o;
        logic [3:0]  m;
        logic [1:0]  s;
        logic        x;
        for (int k = 0; k < 4; k++) begin
          o = 16'($urandom); m = 4'($urandom); s = 2'($urandom); x = 1'($urandom);
          send(o, m, s, x, model(LINE, o, m, s, x), w);
        end
        idle();
      end
      begin
        int n = 0;
        logic [127:0] held;
        @(posedge clk); #1;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        held = out_data;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle=%0d got v=%b d=%h want v=1 d=%h",
                     c, out_valid, out_data, held);
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready cycle=%0d got=%b want=0", c, in_ready);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_reset_midflight();
    int w;
    exp_t e;
    out_ready = 1'b0;
    send({4'd1, 4'd2, 4'd3, 4'd4}, 4'b1111, 2'b00, 1'b0, model(LINE, 16'h1234, 4'b1111, 2'b00, 1'b0), w);
    send({4'd8, 4'd4, 4'd0, 4'd12}, 4'b1111, 2'b10, 1'b0, model(LINE, 16'h840C, 4'b1111, 2'b10, 1'b0), w);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    checks++;
    if ({out_valid, out_data, out_mask, out_misaligned} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got v=%b d=%h m=%b x=%b want all 0",
               out_valid, out_data, out_mask, out_misaligned);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_ghost cycle=%0d out_valid got=%b want=0", c, out_valid);
      end
    end
    @(posedge clk); #1;
    e = model(LINE, 16'hA6F3, 4'b1101, 2'b01, 1'b1);
    send(16'hA6F3, 4'b1101, 2'b01, 1'b1, e, w);
    idle();
    check_latency("midreset");
    wait_drain("midreset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_byte_zext();
    test_byte_sext();
    test_half_mask();
    test_word();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/vload_lane_aligner.md
Name: vload_lane_aligner

Overview:
- Pipelined, multi-lane successor to the single-word load data translator in the vector memory unit.
- Takes one wide data-memory line per transfer and, for each of NUMLANES lanes, extracts the byte, halfword or word at that lane's byte offset.
- Zero- or sign-extends each element to WIDTH and delivers the lane vector to the vector register-file writeback path under a valid/ready handshake.
- Adds lane masking, misalignment flagging and backpressure.

Parameters:
- WIDTH, 32, lane element width; multiple of 32, at least 32.
- LINEWIDTH, 128, memory line width in bits; power of two, at least 32.
- LOG2LINEBYTES, 4, log2(LINEWIDTH/8).
- NUMLANES, 4, number of output lanes.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  input transfer valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  LINEWIDTH  memory line; byte k = in_data[LINEWIDTH-1-8k -: 8] (big-endian).
- in_offsets  input  NUMLANES*LOG2LINEBYTES  per-lane byte offset; lane i at [i*LOG2LINEBYTES +: LOG2LINEBYTES].
- in_lanemask  input  NUMLANES  lane enables.
- load_size  input  2  00 byte, 01 halfword, 10/11 word.
- load_sign_ext  input  1  1 sign-extend, 0 zero-extend.
- out_valid  output  1  output transfer valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  NUMLANES*WIDTH  extended elements; lane i at [i*WIDTH +: WIDTH].
- out_mask  output  NUMLANES  registered copy of in_lanemask.
- out_misaligned  output  NUMLANES  per-lane misalignment flag, masked by lane enable.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_mask=0, out_misaligned=0, all internal valids=0.
- Reset mid-operation discards every in-flight transfer; nothing is emitted for it.
- Input handshake: a transfer is accepted when in_valid && in_ready. load_size and load_sign_ext are sampled with it.
- Output handshake: a transfer completes when out_valid && out_ready.
- Pipeline: two register stages, latency exactly 2 cycles from acceptance to out_valid when there is no stall.
  - S1 registers the raw selected element per lane (32 bits, left-zero-padded), plus size, sign_ext, mask and misaligned flags.
  - S2 registers the extended result.
- Flow control:
  - s2_free = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free.
  - Full throughput is 1 transfer per cycle.
  - While stalled, all S1/S2 registers hold and out_data stays stable while out_valid=1.
- Simultaneous output completion and S1 advance in the same cycle: S2 loads the new data and out_valid stays 1 (no bubble).
- Element selection per lane, with offset o:
  - byte: bytes o. Misaligned never set.
  - halfword: effective offset o with bit0 forced 0; bytes eo, eo+1. Misaligned = o[0].
  - word: effective offset o with bits[1:0] forced 0; bytes eo..eo+3. Misaligned = |o[1:0].
  - The lower-numbered byte is always the most significant.
- Extension:
  - byte/half: upper bits filled with load_sign_ext & element MSB, out to WIDTH.
  - word: bits 31:0 = word; bits WIDTH-1:32 = load_sign_ext & bit31. With WIDTH=32 the word passes through unchanged.
- Masked lanes (in_lanemask[i]=0) output data 0 and misaligned 0; out_mask[i]=0. Masking affects data only, not handshake.
- All lanes may select the same offset; there are no port conflicts.
- Offsets are taken modulo the line size, so there is no wrap beyond the line.
- in_data, in_offsets and in_lanemask are ignored when not accepted.

Test Plan:
(Defaults; line 0x00112233_44556677_8899AABB_CCDDEEFF, so byte k = 0x(k)(k) pattern, byte0=0x00 … byte15=0xFF.)
- Byte zero-ext, offsets {0,5,15,8}, mask 1111 → lanes 0x00000000, 0x00000055, 0x000000FF, 0x00000088; out_valid exactly 2 cycles after accept.
- Byte sign-ext, offsets {8,15,1,10} → 0xFFFFFF88, 0xFFFFFFFF, 0x00000011, 0xFFFFFFAA.
- Half sign-ext, offsets {10,5,0,14}, mask 1011 → lane0 0xFFFFAABB; lane1 0x00004455 with misaligned=1; lane2 data 0 with out_mask[2]=0 and misaligned 0; lane3 0xFFFFEEFF.
- Word, offsets {12,0,7,4} → 0xCCDDEEFF, 0x00112233, 0x44556677 with misaligned=1, 0x44556677.
- Backpressure: 4 back-to-back transfers, out_ready low for 3 cycles after the first out_valid. Required: in_ready drops once both stages are full, no loss or duplication, output order preserved, out_data stable while held.
- Reset asserted while 2 transfers are in flight → next cycle out_valid=0 and outputs zero; a new transfer accepted afterwards emerges 2 cycles later with correct data.
